norm_shift_unit: RTL and testbench
==================================

NORM_SHIFT_UNIT -- requirements
Module: norm_shift_unit

Interface
REQ-001 The block SHALL take parameter MW, default 24, mantissa width in bits (including hidden bit), legal range 8..64.
REQ-002 The block SHALL take parameter EW, default 8, biased exponent width in bits.
REQ-003 The block SHALL use parameter CW, default $clog2(MW), shift-count width, derived from MW and not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 resetBar  input  1  reset, synchronous, active-low.
REQ-006 inValid  input  1  upstream operand valid.
REQ-007 inReady  output  1  block can accept operand this cycle.
REQ-008 cOut  input  1  carry-out of mantissa adder; 1 requests a right shift by 1.
REQ-009 mantIn  input  MW  unnormalised mantissa.
REQ-010 expIn  input  EW  biased exponent before normalisation.
REQ-011 outValid  output  1  result valid.
REQ-012 outReady  input  1  downstream accepts result.
REQ-013 mantOut  output  MW  normalised mantissa, MSB set unless zero/underflow/overflow.
REQ-014 expOut  output  EW  adjusted biased exponent.
REQ-015 LRbar  output  1  0 = right shift applied, 1 = left shift (or none).
REQ-016 numBits  output  CW  shift distance applied.
REQ-017 zero, underflow, overflow  output  1 each  exception flags, mutually exclusive.

Function
REQ-018 Transfer SHALL occur on input when inValid&inReady and on output when outValid&outReady.
REQ-019 Pipeline SHALL have 2 register stages (S1: operand + leading-zero count; S2: shifted result + flags); latency from input transfer to outValid SHALL be exactly 2 cycles with outReady held high.
REQ-020 Each stage SHALL advance when it is empty or the following stage advances in the same cycle; inReady = ~S1valid | S1advance; full throughput of 1 operand/cycle with no bubbles.
REQ-021 While outReady=0 with outValid=1, all output ports SHALL hold stable.
REQ-022 cOut=1: LRbar=0, numBits=1, mantOut={1'b1, mantIn[MW-1:1]}, expOut=expIn+1.
REQ-023 cOut=1 and expIn+1 = all-ones: overflow=1, expOut=all-ones, mantOut=0.
REQ-024 cOut=0, mantIn≠0: n = count of leading zeros of mantIn (0..MW-1); LRbar=1, numBits=n, mantOut=mantIn<<n, expOut=expIn-n.
REQ-025 cOut=0, mantIn≠0, n ≥ expIn: underflow=1 (flush to zero), mantOut=0, expOut=0, numBits=n, LRbar=1.
REQ-026 cOut=0, mantIn=0: zero=1, numBits=0, LRbar=1, mantOut=0, expOut=0.
REQ-027 Priority: cOut over zero detection; zero over underflow.
REQ-028 Exponent arithmetic SHALL be done at EW+1 bits to detect wrap; no result SHALL wrap silently.

Reset
REQ-029 With resetBar=0 at a rising edge: both stage valids cleared, outValid=0, inReady=1 on the following cycle, mantOut=0, expOut=0, numBits=0, LRbar=1, all flags 0.
REQ-030 Reset mid-operation SHALL discard in-flight operands; no result for them SHALL ever appear.

Structure
REQ-031 Package fpu_norm_pkg SHALL hold default MW/EW constants and the flag-encoding enum; shared with the FPU adder.
REQ-032 Leading-zero count SHALL be a combinational sub-module lzc_tree (parametrised by MW, log-depth tree, outputs count and all-zero).
REQ-033 Implementation SHALL be synthesizable, no latches, every combinational output assigned on every path.

Verification (MW=24, EW=8)
REQ-034 cOut=1, mantIn=24'h800000, expIn=10 -> 2 cycles later mantOut=24'hC00000, expOut=11, LRbar=0, numBits=1.
REQ-035 cOut=0, mantIn=24'h000100, expIn=100 -> numBits=15, mantOut=24'h800000, expOut=85, LRbar=1.
REQ-036 cOut=0, mantIn=0 -> zero=1, numBits=0, expOut=0; then mantIn=24'h000001, expIn=20 -> underflow=1, numBits=23, mantOut=0.
REQ-037 cOut=1, expIn=254 -> overflow=1, expOut=255, mantOut=0.
REQ-038 Back-to-back 4 operands, outReady low for cycles 2-4 -> inReady drops after 2 accepted, outputs stable, all 4 results emerge in order, none lost or duplicated.
REQ-039 resetBar=0 for one edge with 2 operands in flight -> outValid=0 next cycle, no stale result after reset release.

Source files
------------

// File: rtl/fpu_norm_pkg.sv
// Shared FPU normalisation definitions: default widths and result flag encoding.
package fpu_norm_pkg;

  localparam int NORM_MW = 24;
  localparam int NORM_EW = 8;

  // Exception classification of a normalised result; at most one applies.
  typedef enum logic [1:0] {
    FLAG_NONE      = 2'd0,
    FLAG_ZERO      = 2'd1,
    FLAG_UNDERFLOW = 2'd2,
    FLAG_OVERFLOW  = 2'd3
  } norm_flag_e;

endpackage

// File: rtl/norm_shift_unit_if.sv
// Operand/result handshake bundle for the normalise-and-shift unit.
interface norm_shift_unit_if
  import fpu_norm_pkg::*;
#(
  parameter int MW = NORM_MW,
  parameter int EW = NORM_EW,
  parameter int CW = $clog2(MW)
);
  logic          inValid;
  logic          inReady;
  logic          cOut;
  logic [MW-1:0] mantIn;
  logic [EW-1:0] expIn;
  logic          outValid;
  logic          outReady;
  logic [MW-1:0] mantOut;
  logic [EW-1:0] expOut;
  logic          LRbar;
  logic [CW-1:0] numBits;
  logic          zero;
  logic          underflow;
  logic          overflow;

  modport master (
    output inValid, cOut, mantIn, expIn, outReady,
    input  inReady, outValid, mantOut, expOut, LRbar, numBits, zero, underflow, overflow
  );

  modport slave (
    input  inValid, cOut, mantIn, expIn, outReady,
    output inReady, outValid, mantOut, expOut, LRbar, numBits, zero, underflow, overflow
  );
endinterface

// File: rtl/lzc_tree.sv
// Combinational leading-zero counter built as a log-depth binary tree.
module lzc_tree #(
  parameter int MW = 24,
  parameter int CW = $clog2(MW)
) (
  input  logic [MW-1:0] data,
  output logic [CW-1:0] count,
  output logic          all_zero
);
  localparam int LV = $clog2(MW);
  localparam int P  = 1 << LV;

  // Pad at the LSB end so the leading-zero count of a nonzero word is unchanged.
  logic [P-1:0] padded;
  assign padded = P'(data) << (P - MW);

  // Level l holds P>>l nodes, node 0 being the most significant slice.
  for (genvar l = 0; l <= LV; l++) begin : g_lvl
    localparam int N = P >> l;
    logic [N-1:0]         v;
    logic [N-1:0][CW-1:0] c;
    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_bit
        assign v[j] = padded[P-1-j];
      end
      assign c = '0;
    end else begin : g_node
      for (genvar i = 0; i < N; i++) begin : g_n
        // Right half only counts once the whole left half is zero; its count
        // is below the half size, so OR-ing in the half size is the addition.
        assign v[i] = g_lvl[l-1].v[2*i] | g_lvl[l-1].v[2*i+1];
        assign c[i] = g_lvl[l-1].v[2*i] ? g_lvl[l-1].c[2*i]
                                         : (g_lvl[l-1].c[2*i+1] | CW'(1 << (l - 1)));
      end
    end
  end

  assign count    = g_lvl[LV].c[0];
  assign all_zero = ~g_lvl[LV].v[0];
endmodule

// File: rtl/norm_shift_unit.sv
// Two-stage mantissa normaliser: S1 captures operand and leading-zero count,
// S2 holds the shifted mantissa, adjusted exponent and exception flag.
module norm_shift_unit
  import fpu_norm_pkg::*;
#(
  parameter int MW = NORM_MW,
  parameter int EW = NORM_EW,
  parameter int CW = $clog2(MW)
) (
  input logic              clk,
  input logic              resetBar,
  norm_shift_unit_if.slave bus
);
  // Exponent math is widened so increments and decrements never wrap unseen.
  localparam int XW = (EW + 1 > CW + 1) ? EW + 1 : CW + 1;
  localparam logic [XW-1:0] EXP_MAX = {{(XW-EW){1'b0}}, {EW{1'b1}}};

  function automatic logic [XW-1:0] exp_inc(input logic [EW-1:0] e);
    return XW'(e) + XW'(1);
  endfunction

  function automatic logic [XW-1:0] exp_sub(input logic [EW-1:0] e, input logic [CW-1:0] n);
    return XW'(e) - XW'(n);
  endfunction

  logic          vld_p1, vld_p2;
  logic          cout_p1, zero_p1;
  logic [MW-1:0] mant_p1;
  logic [EW-1:0] exp_p1;
  logic [CW-1:0] lz_p1;

  logic [MW-1:0] mant_p2;
  logic [EW-1:0] exp_p2;
  logic          lr_p2;
  logic [CW-1:0] nb_p2;
  norm_flag_e    flag_p2;

  logic [CW-1:0] lz_cnt;
  logic          lz_zero;
  logic          s1_adv, in_acc;

  lzc_tree #(.MW(MW), .CW(CW)) u_lzc (
    .data     (bus.mantIn),
    .count    (lz_cnt),
    .all_zero (lz_zero)
  );

  assign s1_adv      = vld_p1 & (~vld_p2 | bus.outReady);
  assign bus.inReady = ~vld_p1 | s1_adv;
  assign in_acc      = bus.inValid & bus.inReady;

  // Stage valids: S1 fills on accept, S2 fills when S1 moves down.
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_acc)      vld_p1 <= 1'b1;
      else if (s1_adv) vld_p1 <= 1'b0;
      if (s1_adv)            vld_p2 <= 1'b1;
      else if (bus.outReady) vld_p2 <= 1'b0;
    end
  end

  // ---- S1: operand + leading-zero count ----
  // S1 payload captures the accepted operand.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      cout_p1 <= bus.cOut;
      mant_p1 <= bus.mantIn;
      exp_p1  <= bus.expIn;
      lz_p1   <= lz_cnt;
      zero_p1 <= lz_zero;
    end
  end

  logic [MW-1:0] nxt_mant;
  logic [EW-1:0] nxt_exp;
  logic          nxt_lr;
  logic [CW-1:0] nxt_nb;
  norm_flag_e    nxt_flag;
  logic [XW-1:0] exp_up, exp_dn;

  // Shift decision: carry-out right shift beats zero, zero beats underflow.
  always_comb begin
    nxt_mant = '0;
    nxt_exp  = '0;
    nxt_lr   = 1'b1;
    nxt_nb   = '0;
    nxt_flag = FLAG_NONE;
    exp_up   = exp_inc(exp_p1);
    exp_dn   = exp_sub(exp_p1, lz_p1);
    if (cout_p1) begin
      nxt_lr = 1'b0;
      nxt_nb = CW'(1);
      if (exp_up >= EXP_MAX) begin
        nxt_flag = FLAG_OVERFLOW;
        nxt_exp  = '1;
      end else begin
        nxt_mant = {1'b1, mant_p1[MW-1:1]};
        nxt_exp  = exp_up[EW-1:0];
      end
    end else if (zero_p1) begin
      nxt_flag = FLAG_ZERO;
    end else begin
      nxt_nb = lz_p1;
      if (XW'(lz_p1) >= XW'(exp_p1)) begin
        nxt_flag = FLAG_UNDERFLOW;
      end else begin
        nxt_mant = mant_p1 << lz_p1;
        nxt_exp  = exp_dn[EW-1:0];
      end
    end
  end

  // ---- S2: shifted result + flags ----
  // S2 result register, cleared by reset so idle outputs read as defined values.
  always_ff @(posedge clk) begin
    if (!resetBar) begin
      mant_p2 <= '0;
      exp_p2  <= '0;
      lr_p2   <= 1'b1;
      nb_p2   <= '0;
      flag_p2 <= FLAG_NONE;
    end else if (s1_adv) begin
      mant_p2 <= nxt_mant;
      exp_p2  <= nxt_exp;
      lr_p2   <= nxt_lr;
      nb_p2   <= nxt_nb;
      flag_p2 <= nxt_flag;
    end
  end

  assign bus.outValid  = vld_p2;
  assign bus.mantOut   = mant_p2;
  assign bus.expOut    = exp_p2;
  assign bus.LRbar     = lr_p2;
  assign bus.numBits   = nb_p2;
  assign bus.zero      = (flag_p2 == FLAG_ZERO);
  assign bus.underflow = (flag_p2 == FLAG_UNDERFLOW);
  assign bus.overflow  = (flag_p2 == FLAG_OVERFLOW);
endmodule

// File: tb/tb_norm_shift_unit.sv
// Randomised and directed bench for norm_shift_unit with a queue scoreboard.
module tb_norm_shift_unit;
  localparam int MW = 24;
  localparam int EW = 8;

  logic clk = 1'b0;
  logic resetBar = 1'b0;
  always #5 clk = ~clk;

  norm_shift_unit_if #(.MW(MW), .EW(EW)) bus ();

  norm_shift_unit #(.MW(MW), .EW(EW)) dut (
    .clk      (clk),
    .resetBar (resetBar),
    .bus      (bus)
  );

  typedef struct {
    logic [23:0] m;
    logic [7:0]  e;
    logic        lr;
    logic [4:0]  nb;
    logic        z, uf, ov;
    int          cyc;
    logic        lat;
  } res_t;

  res_t sb[$];
  res_t hs;
  logic held = 1'b0;
  logic lat_mode = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Normalisation rules written straight from the arithmetic definition.
  function automatic res_t model(input logic c, input logic [23:0] m, input logic [7:0] e);
    res_t r;
    int n;
    r.m = '0; r.e = '0; r.lr = 1'b1; r.nb = '0;
    r.z = 1'b0; r.uf = 1'b0; r.ov = 1'b0; r.cyc = 0; r.lat = 1'b0;
    n = 0;
    if (c) begin
      r.lr = 1'b0;
      r.nb = 5'd1;
      if (int'(e) + 1 >= 255) begin
        r.ov = 1'b1;
        r.e  = 8'hFF;
      end else begin
        r.m = (m >> 1) + 24'h800000;
        r.e = 8'(int'(e) + 1);
      end
    end else if (m == 0) begin
      r.z = 1'b1;
    end else begin
      while (m[23-n] == 1'b0) n++;
      r.nb = 5'(n);
      if (n >= int'(e)) r.uf = 1'b1;
      else begin
        r.m = 24'(m * (2 ** n));
        r.e = 8'(int'(e) - n);
      end
    end
    return r;
  endfunction

  task automatic compare_out(input string pfx, input res_t x);
    check_val({pfx, "_mant"}, 64'(bus.mantOut), 64'(x.m));
    check_val({pfx, "_exp"},  64'(bus.expOut),  64'(x.e));
    check_val({pfx, "_lr"},   64'(bus.LRbar),   64'(x.lr));
    check_val({pfx, "_nb"},   64'(bus.numBits), 64'(x.nb));
    check_val({pfx, "_flags"}, 64'({bus.zero, bus.underflow, bus.overflow}),
              64'({x.z, x.uf, x.ov}));
  endtask

  // One clock cycle: drive inputs, then account for the transfers of this cycle.
  task automatic step(input logic iv, input logic c, input logic [23:0] m,
                      input logic [7:0] e, input logic ordy, output logic acc);
    res_t x;
    @(negedge clk);
    bus.inValid  = iv;
    bus.cOut     = c;
    bus.mantIn   = m;
    bus.expIn    = e;
    bus.outReady = ordy;
    #1;
    cyc++;
    if (held) compare_out("hold", hs);
    acc = bus.inValid & bus.inReady;
    if (bus.outValid && bus.outReady) begin
      if (sb.size() == 0) check_val("spurious_out", 64'(1), 64'(0));
      else begin
        x = sb.pop_front();
        compare_out("res", x);
        if (x.lat) check_val("latency", 64'(cyc - x.cyc), 64'(2));
      end
    end
    held = bus.outValid & ~bus.outReady;
    if (held) begin
      hs.m = bus.mantOut; hs.e = bus.expOut; hs.lr = bus.LRbar; hs.nb = bus.numBits;
      hs.z = bus.zero; hs.uf = bus.underflow; hs.ov = bus.overflow;
    end
    if (acc) begin
      x = model(c, m, e);
      x.cyc = cyc;
      x.lat = lat_mode;
      sb.push_back(x);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    resetBar = 1'b0;
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    sb.delete();
    held = 1'b0;
    repeat (n) @(negedge clk);
    resetBar = 1'b1;
    #1;
    check_val("rst_outValid", 64'(bus.outValid), 64'(0));
    check_val("rst_inReady",  64'(bus.inReady),  64'(1));
    check_val("rst_mant",     64'(bus.mantOut),  64'(0));
    check_val("rst_exp",      64'(bus.expOut),   64'(0));
    check_val("rst_nb",       64'(bus.numBits),  64'(0));
    check_val("rst_lr",       64'(bus.LRbar),    64'(1));
    check_val("rst_flags", 64'({bus.zero, bus.underflow, bus.overflow}), 64'(0));
  endtask

  // Present one operand until accepted, with a bounded wait.
  task automatic send(input logic c, input logic [23:0] m, input logic [7:0] e, input logic ordy);
    logic acc;
    int   tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 50) begin
      step(1'b1, c, m, e, ordy, acc);
      tries++;
    end
    if (!acc) check_val("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b1, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n_acc;
    logic [23:0] ops_m [4];
    logic [23:0] rm;
    logic [7:0]  re;
    int   sh;

    bus.inValid = 1'b0; bus.cOut = 1'b0; bus.mantIn = '0; bus.expIn = '0; bus.outReady = 1'b0;
    do_reset(2);

    // Directed cases with outReady high, latency tracked.
    lat_mode = 1'b1;
    send(1'b1, 24'h800000, 8'd10, 1'b1);
    idle(3);
    send(1'b0, 24'h000100, 8'd100, 1'b1);
    idle(3);
    send(1'b0, 24'h000000, 8'd55, 1'b1);
    send(1'b0, 24'h000001, 8'd20, 1'b1);
    send(1'b1, 24'h9ABCDE, 8'd254, 1'b1);
    send(1'b1, 24'h123456, 8'd255, 1'b1);
    send(1'b0, 24'h000004, 8'd21, 1'b1);
    send(1'b0, 24'h000004, 8'd22, 1'b1);
    send(1'b0, 24'hFFFFFF, 8'd0, 1'b1);
    send(1'b1, 24'hFFFFFF, 8'd0, 1'b1);
    idle(4);
    lat_mode = 1'b0;

    // Back-to-back four operands with the output stalled early on.
    ops_m[0] = 24'h400000; ops_m[1] = 24'h000F00; ops_m[2] = 24'h000000; ops_m[3] = 24'h0000FF;
    n_acc = 0;
    for (int t = 0; t < 4; t++) begin
      step(1'b1, 1'b0, ops_m[n_acc], 8'(60 + n_acc), (t == 0), acc);
      if (acc) n_acc++;
    end
    check_val("stall_accepted", 64'(n_acc), 64'(2));
    check_val("stall_inReady", 64'(bus.inReady), 64'(0));
    for (int t = 0; t < 20 && n_acc < 4; t++) begin
      step(1'b1, 1'b0, ops_m[n_acc], 8'(60 + n_acc), 1'b1, acc);
      if (acc) n_acc++;
    end
    check_val("stall_all_in", 64'(n_acc), 64'(4));
    idle(4);
    check_val("stall_drained", 64'(sb.size()), 64'(0));

    // Reset with two operands in flight: nothing may emerge afterwards.
    step(1'b1, 1'b0, 24'h001000, 8'd90, 1'b0, acc);
    step(1'b1, 1'b1, 24'h801000, 8'd90, 1'b0, acc);
    do_reset(1);
    idle(6);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 1500; i++) begin
      sh = $urandom_range(0, 24);
      rm = 24'($urandom) >> sh;
      if ($urandom_range(0, 15) == 0) rm = '0;
      re = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) re = 8'($urandom_range(250, 255));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rm, re,
           $urandom_range(0, 9) < 7, acc);
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    check_val("final_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
